data_demodulate_3x3: RTL and testbench
======================================

Name: data_demodulate_3x3

Overview:
- Output-side counterpart of the 3x3 window data-modulation stage.
- Takes the stream of filtered window-centre results, one per interior pixel, and rebuilds a full-size raster frame of IMG_WIDTH x IMG_HEIGHT pixels.
- Emits BORDER_VALUE at border positions (where no 3x3 window exists) without consuming input.
- Tracks row/column, pulses done_o on the last pixel of the frame, and feeds the frame writer downstream.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 640, frame width in pixels (>=3)
IMG_HEIGHT, 480, frame height in pixels (>=3)
BORDER_VALUE, 0, constant emitted at border positions (DATA_WIDTH bits)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  begin one frame; sampled only in IDLE
data_i  input  DATA_WIDTH  filtered interior pixel
valid_i  input  1  data_i valid
ready_o  output  1  block accepts data_i this cycle (combinational)
data_o  output  DATA_WIDTH  raster output pixel (registered)
valid_o  output  1  data_o valid (registered)
row_o  output  clog2(IMG_HEIGHT)  row of data_o
col_o  output  clog2(IMG_WIDTH)  column of data_o
done_o  output  1  high with valid_o of the final pixel (H-1,W-1)
busy_o  output  1  high while in RUN

Behaviour:
- Reset (async, rst=1): state=IDLE; the row/col position counters = 0; data_o=0, valid_o=0, row_o=0, col_o=0, done_o=0, busy_o=0. Reset mid-frame abandons the frame with no done_o; the next start_i restarts at (0,0).
- States: IDLE, RUN.
  - IDLE -> RUN on start_i=1; position counters cleared to (0,0).
  - RUN -> IDLE in the cycle the pixel (H-1,W-1) is emitted.
  - start_i in RUN is ignored.
- Border position: row==0, row==H-1, col==0 or col==W-1.
- RUN, border position:
  - emit BORDER_VALUE every cycle and advance; no input is consumed.
  - ready_o=0.
- RUN, interior position:
  - ready_o=1.
  - If valid_i=1: emit data_i and advance.
  - Else: stall, with no emission and no advance.
- ready_o=0 in IDLE; valid_i is ignored whenever ready_o=0, and data is not consumed.
- Emission: data_o, valid_o, row_o and col_o are registered with the position being emitted; latency is 1 cycle from the emit decision (or input handshake) to valid_o.
  - valid_o=0 in non-emitting cycles; data_o/row_o/col_o then hold their last values.
- Advance: col+1. At col==W-1: col=0, row+1. At the last pixel, the counters return to (0,0).
- done_o: registered, high exactly in the cycle valid_o carries (H-1,W-1); a 1-cycle pulse.
- Stall-free frame: W*H consecutive valid_o cycles and (W-2)*(H-2) accepted inputs, consumed in raster order.
- Simultaneous start_i and a final emission: the final emission completes first; start_i is not honoured that cycle because state is RUN.

Optional Feature:
DEMOD_BACKPRESSURE_EN
- Defined:
  - Adds input port out_ready_i (1 bit).
  - An output beat transfers when valid_o && out_ready_i.
  - While valid_o && !out_ready_i: data_o/row_o/col_o/done_o hold, and the position does not advance.
  - ready_o = RUN && interior && (!valid_o || out_ready_i).
  - Emission occurs only when the output register is empty or being drained.
  - done_o stays high until the last pixel transfers; the return to IDLE happens on that transfer.
- Undefined: no out_ready_i port; the downstream is always ready; behaviour as above.

Test Plan:
1. Reset: assert rst mid-operation for 2 cycles -> all outputs 0, ready_o=0, busy_o=0; the next start_i gives first output (0,0) = BORDER_VALUE.
2. IMG_WIDTH=5, IMG_HEIGHT=4, valid_i held 1, data_i = 1..6 -> 20 consecutive valid_o cycles starting 1 cycle after RUN begins.
   - Interior order: (1,1)=1, (1,2)=2, (1,3)=3, (2,1)=4, (2,2)=5, (2,3)=6; all other positions = 0.
   - ready_o high exactly 6 cycles; done_o high only with (3,4).
3. Same config, valid_i low for 3 cycles while at (1,2) -> valid_o low for 3 cycles, position stays (1,2), data 2 emitted afterwards; frame takes 23 cycles; done_o still a single pulse.
4. valid_i=1 with data 0xAA in IDLE and at border positions -> not consumed (ready_o=0), 0xAA never appears on data_o. start_i pulsed at (2,2) -> ignored, frame completes normally.
5. rst asserted when the output is at (2,0) -> immediate IDLE, no done_o; start_i then restarts at (0,0) and a full 20-pixel frame follows.
6. (DEMOD_BACKPRESSURE_EN) out_ready_i low for 2 cycles while data_o shows (0,3) -> data_o/col_o held 3 cycles, ready_o low, no position skipped; sequence resumes at (0,4).

Source files
------------

// File: rtl/data_demodulate_3x3.sv
`default_nettype none
// ============================================================================
// Module   : data_demodulate_3x3
// Purpose  : Rebuilds a full IMG_WIDTH x IMG_HEIGHT raster frame from the
//            stream of 3x3-window centre results (one per interior pixel).
//            Border positions, where no 3x3 window exists, are filled with
//            BORDER_VALUE without consuming input. The output stream is
//            tagged with row/column and done_o marks the last pixel.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start_i      in   begin one frame (sampled only in IDLE)
//   data_i       in   filtered interior pixel
//   valid_i      in   data_i valid
//   out_ready_i  in   downstream ready (only with DEMOD_BACKPRESSURE_EN)
//   ready_o      out  data_i accepted this cycle (combinational)
//   data_o       out  raster pixel (registered)
//   valid_o      out  data_o valid (registered)
//   row_o        out  row of data_o
//   col_o        out  column of data_o
//   done_o       out  high with the final pixel (H-1, W-1)
//   busy_o       out  high while a frame is in progress
// Build option:
//   DEMOD_BACKPRESSURE_EN - adds out_ready_i; the output register holds
//                           its beat until the downstream accepts it.
// ============================================================================
module data_demodulate_3x3 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter logic [DATA_WIDTH-1:0] BORDER_VALUE = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  input  logic                          valid_i,
`ifdef DEMOD_BACKPRESSURE_EN
  input  logic                          out_ready_i,
`endif
  output logic                          ready_o,
  output logic [DATA_WIDTH-1:0]         data_o,
  output logic                          valid_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o,
  output logic [$clog2(IMG_WIDTH)-1:0]  col_o,
  output logic                          done_o,
  output logic                          busy_o
);

  localparam int c_ROW_W = $clog2(IMG_HEIGHT);
  localparam int c_COL_W = $clog2(IMG_WIDTH);
  localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(IMG_HEIGHT - 1);
  localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(IMG_WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Position of the pixel to be emitted next
  logic [c_ROW_W-1:0] r_row;
  logic [c_COL_W-1:0] r_col;

  // Output register
  logic [DATA_WIDTH-1:0] r_data_o;
  logic                  r_valid_o;
  logic [c_ROW_W-1:0]    r_row_o;
  logic [c_COL_W-1:0]    r_col_o;
  logic                  r_done_o;

  logic w_border;
  logic w_last;
  logic w_out_free;   // output register can take a new beat this cycle
  logic w_final_hold; // last pixel of the frame still waits in the register
  logic w_emit;
  logic w_ready;

  assign w_border = (r_row == '0) || (r_row == c_LAST_ROW) ||
                    (r_col == '0) || (r_col == c_LAST_COL);
  assign w_last   = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

`ifdef DEMOD_BACKPRESSURE_EN
  logic w_xfer;
  assign w_xfer       = r_valid_o && out_ready_i;
  assign w_out_free   = !r_valid_o || out_ready_i;
  // After the last pixel is loaded the counters already point at (0,0);
  // emission must stop until that final beat has been taken downstream.
  assign w_final_hold = r_valid_o && r_done_o;
`else
  assign w_out_free   = 1'b1;
  assign w_final_hold = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and emit/accept decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_out_free && !w_final_hold) begin
          // Border pixels are generated locally; interior ones need input.
          w_ready = !w_border;
          w_emit  = w_border || valid_i;
        end
`ifdef DEMOD_BACKPRESSURE_EN
        if (w_xfer && r_done_o) begin
          w_next_state = S_IDLE;
        end
`else
        if (w_emit && w_last) begin
          w_next_state = S_IDLE;
        end
`endif
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Raster position counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (r_state == S_IDLE) begin
      if (start_i) begin
        r_row <= '0;
        r_col <= '0;
      end
    end else if (w_emit) begin
      if (r_col == c_LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_o  <= '0;
      r_valid_o <= 1'b0;
      r_row_o   <= '0;
      r_col_o   <= '0;
      r_done_o  <= 1'b0;
    end else if (w_emit) begin
      r_data_o  <= w_border ? BORDER_VALUE : data_i;
      r_valid_o <= 1'b1;
      r_row_o   <= r_row;
      r_col_o   <= r_col;
      r_done_o  <= w_last;
    end else begin
`ifdef DEMOD_BACKPRESSURE_EN
      // Beat drained without replacement: register becomes empty.
      if (w_xfer) begin
        r_valid_o <= 1'b0;
        r_done_o  <= 1'b0;
      end
`else
      r_valid_o <= 1'b0;
      r_done_o  <= 1'b0;
`endif
    end
  end

  assign ready_o = w_ready;
  assign data_o  = r_data_o;
  assign valid_o = r_valid_o;
  assign row_o   = r_row_o;
  assign col_o   = r_col_o;
  assign done_o  = r_done_o;
  assign busy_o  = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_data_demodulate_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_demodulate_3x3
// Purpose  : Self-checking bench for data_demodulate_3x3 on a 5x4 frame.
//            Expected raster beats are queued per frame from a reference
//            model; a monitor pops and compares each output beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_demodulate_3x3;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int NI = (W - 2) * (H - 2);
  localparam logic [DW-1:0] BV = 8'h00;

  logic                   clk;
  logic                   rst;
  logic                   start_i;
  logic [DW-1:0]          data_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [DW-1:0]          data_o;
  logic                   valid_o;
  logic [$clog2(H)-1:0]   row_o;
  logic [$clog2(W)-1:0]   col_o;
  logic                   done_o;
  logic                   busy_o;

  data_demodulate_3x3 #(
    .DATA_WIDTH  (DW),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .BORDER_VALUE(BV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
`ifdef DEMOD_BACKPRESSURE_EN
    .out_ready_i(1'b1),
`endif
    .ready_o    (ready_o),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .row_o      (row_o),
    .col_o      (col_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int row;
    int col;
    int data;
    bit done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pack_beat(input int r, input int c, input int d, input bit dn);
    return (r << 12) | (c << 9) | (d << 1) | int'(dn);
  endfunction

  // Monitor: every output beat must match the next expected raster pixel.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_beat: got r%0d c%0d d0x%0h, expected no beat",
                   row_o, col_o, data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("beat r%0d c%0d", e.row, e.col),
                pack_beat(int'(row_o), int'(col_o), int'(data_o), done_o),
                pack_beat(e.row, e.col, e.data, e.done));
        end
      end else if (done_o) begin
        check("done_without_valid", 1, 0);
      end
    end
  end

  // Reference model: raster scan, border -> BV, interior -> inputs in order.
  task automatic build_expected(input logic [DW-1:0] items[NI]);
    int k;
    exp_t e;
    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.row  = r;
        e.col  = c;
        e.done = (r == H - 1) && (c == W - 1);
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          e.data = int'(BV);
        end else begin
          e.data = int'(items[k]);
          k++;
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // mode 0: valid_i always high; 1: 3-cycle stall after first input;
  // 2: random valid_i;  3: random valid_i plus a start_i pulse at (2,2).
  // abort: assert rst when the output shows (2,0).
  task automatic run_frame(input int mode, input bit abort);
    logic [DW-1:0] items[NI];
    int  idx;
    int  stall;
    int  cyc;
    int  frame_cycles;
    int  rdy;
    bit  counting;
    bit  got_done;
    bit  took;
    bit  pulsed;
    for (int i = 0; i < NI; i++) begin
      items[i] = DW'($urandom_range(1, 254));
      if (items[i] == 8'hAA) items[i] = 8'h55;
    end
    idx = 0; stall = 0; cyc = 0; frame_cycles = 0; rdy = 0;
    counting = 0; got_done = 0; pulsed = 0;

    // Junk offered in IDLE must never be taken.
    @(posedge clk); #1;
    valid_i = 1'b1;
    data_i  = 8'hAA;
    repeat (2) begin
      @(negedge clk);
      check("idle_ready", int'(ready_o), 0);
    end

    build_expected(items);
    @(posedge clk); #1;
    start_i = 1'b1;
    data_i  = items[0];
    valid_i = (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;

    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check("busy_after_start", int'(busy_o), 1);
        check("no_beat_on_start", int'(valid_o), 0);
      end
      if (cyc == 2) check("first_beat_latency", int'(valid_o), 1);
      if (valid_o) counting = 1;
      if (counting) frame_cycles++;
      if (ready_o) rdy++;
      if (valid_o && done_o) got_done = 1;
      if (abort && valid_o && row_o == 2 && col_o == 0) begin
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", int'(valid_o), 0);
        check("rst_outputs", int'({data_o, row_o, col_o, done_o}), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_ready", int'(ready_o), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.delete();
        valid_i = 1'b0;
        rst = 1'b0;
        return;
      end
      took = ready_o && valid_i;
      @(posedge clk); #1;
      if (took) idx++;
      data_i = (idx < NI) ? items[idx] : 8'hAA;
      start_i = 1'b0;
      case (mode)
        0: valid_i = 1'b1;
        1: begin
          if (idx == 1 && stall < 3) begin
            valid_i = 1'b0;
            stall++;
          end else begin
            valid_i = 1'b1;
          end
        end
        default: begin
          valid_i = 1'($urandom_range(0, 1));
          if (mode == 3 && idx == 4 && !pulsed) begin
            start_i = 1'b1;
            pulsed  = 1;
          end
        end
      endcase
    end

    if (!got_done) check("frame_timeout", 0, 1);
    if (mode == 0) begin
      check("frame_cycles_nostall", frame_cycles, W * H);
      check("ready_cycles_nostall", rdy, NI);
    end
    if (mode == 1) begin
      check("frame_cycles_stall", frame_cycles, W * H + 3);
      check("ready_cycles_stall", rdy, NI + 3);
    end
    @(posedge clk); #1;
    start_i = 1'b0;
    valid_i = 1'b0;
    @(negedge clk);
    check("idle_after_frame", int'(busy_o), 0);
    check("no_beat_after_frame", int'(valid_o), 0);
    check("inputs_consumed", idx, NI);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b0;
    data_i  = '0;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", int'({data_o, row_o, col_o, done_o, valid_o}), 0);
    check("reset_busy", int'(busy_o), 0);
    check("reset_ready", int'(ready_o), 0);
    rst = 1'b0;

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(2, 1'b0);
    run_frame(3, 1'b0);
    run_frame(2, 1'b1);
    run_frame(0, 1'b0);
    run_frame(3, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
